// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the pipeline hazard/stall unit: FSM state encoding,
// default parameter values and the load-use hazard detector.
package hazard_stall_unit_pkg;

    localparam int DEFAULT_MAX_WAIT = 255;
    localparam int DEFAULT_CNT_W    = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    // A load in EX whose destination is read by the instruction in ID.
    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs2_used,
        input logic [4:0] rd,
        input logic       mem_read
    );
        return mem_read && (rd != 5'd0) &&
               ((rd == rs1) || (rs2_used && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle of the hazard/stall unit: stage operand/control
// inputs, stage-register enables, bubble/flush controls and status counters.
interface hazard_stall_unit_if
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic [4:0]       Rs1_id;
    logic [4:0]       Rs2_id;
    logic             Rs2_used_id;
    logic [4:0]       Rd_ex;
    logic             MemRead_ex;
    logic             branch_taken_ex;
    logic             dmem_req;
    logic             dmem_ready;

    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEXWrite;
    logic             EXMEMWrite;
    logic             IDEX_bubble;
    logic             IFID_flush;
    logic             MEMWB_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] mem_stall_cnt;

    // Pipeline datapath side: supplies stage information, consumes controls.
    modport master (
        output Rs1_id, Rs2_id, Rs2_used_id, Rd_ex, MemRead_ex,
               branch_taken_ex, dmem_req, dmem_ready,
        input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
               IDEX_bubble, IFID_flush, MEMWB_bubble,
               mem_timeout, lu_stall_cnt, mem_stall_cnt
    );

    // Hazard unit side.
    modport slave (
        input  Rs1_id, Rs2_id, Rs2_used_id, Rd_ex, MemRead_ex,
               branch_taken_ex, dmem_req, dmem_ready,
        output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
               IDEX_bubble, IFID_flush, MEMWB_bubble,
               mem_timeout, lu_stall_cnt, mem_stall_cnt
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Advance on inc unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall unit: load-use stall, taken-branch flush and a
// data-memory wait freeze with timeout. Stage controls are combinational so
// the pipeline reacts in the same cycle the condition is seen.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_stall_unit_if.slave bus
);

    localparam logic [1:0] S_RUN      = RUN;
    localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
    localparam logic [1:0] S_HALT     = HALT;

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              mem_timeout_r;
    logic              mem_timeout_nxt_s;

    logic              hazard_s;
    logic              mem_miss_s;
    logic              freeze_s;
    logic              lu_inc_s;
    logic              mem_inc_s;

    logic              pc_write_s;
    logic              ifid_write_s;
    logic              idex_write_s;
    logic              exmem_write_s;
    logic              idex_bubble_s;
    logic              ifid_flush_s;
    logic              memwb_bubble_s;

    logic [CNT_W-1:0]  lu_cnt_s;
    logic [CNT_W-1:0]  mem_cnt_s;

    assign hazard_s   = load_use_hazard(bus.Rs1_id, bus.Rs2_id, bus.Rs2_used_id,
                                        bus.Rd_ex, bus.MemRead_ex);
    assign mem_miss_s = bus.dmem_req && !bus.dmem_ready;

    // Next state, wait-cycle count and sticky timeout.
    always_comb begin
        state_nxt_s       = state_r;
        wait_cnt_nxt_s    = wait_cnt_r;
        mem_timeout_nxt_s = mem_timeout_r;
        case (state_r)
            S_RUN: begin
                if (mem_miss_s) begin
                    state_nxt_s    = S_MEM_WAIT;
                    wait_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s    = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    state_nxt_s = S_RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    // This increment brings the count to MAX_WAIT: give up.
                    state_nxt_s       = S_HALT;
                    wait_cnt_nxt_s    = wait_cnt_r + WAIT_ONE;
                    mem_timeout_nxt_s = 1'b1;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
                end
            end
            S_HALT: begin
                state_nxt_s       = S_HALT;
                mem_timeout_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s    = S_RUN;
                wait_cnt_nxt_s = '0;
            end
        endcase
    end

    // Stage controls. A memory freeze dominates, then the branch flush, then
    // the load-use stall. Because a freeze holds every stage register, any
    // branch or hazard present at the time is simply re-evaluated once the
    // pipeline moves again.
    always_comb begin
        pc_write_s     = 1'b1;
        ifid_write_s   = 1'b1;
        idex_write_s   = 1'b1;
        exmem_write_s  = 1'b1;
        idex_bubble_s  = 1'b0;
        ifid_flush_s   = 1'b0;
        memwb_bubble_s = 1'b0;
        freeze_s       = 1'b0;
        lu_inc_s       = 1'b0;
        if (!rst_n) begin
            freeze_s = 1'b0;
        end else begin
            case (state_r)
                S_RUN:      freeze_s = mem_miss_s;
                S_MEM_WAIT: freeze_s = !bus.dmem_ready;
                S_HALT:     freeze_s = 1'b1;
                default:    freeze_s = 1'b0;
            endcase
            if (freeze_s) begin
                pc_write_s     = 1'b0;
                ifid_write_s   = 1'b0;
                idex_write_s   = 1'b0;
                exmem_write_s  = 1'b0;
                memwb_bubble_s = 1'b1;
            end else if (bus.branch_taken_ex) begin
                ifid_flush_s  = 1'b1;
                idex_bubble_s = 1'b1;
            end else if (hazard_s) begin
                pc_write_s    = 1'b0;
                ifid_write_s  = 1'b0;
                idex_bubble_s = 1'b1;
                lu_inc_s      = 1'b1;
            end else begin
                lu_inc_s = 1'b0;
            end
        end
    end

    assign mem_inc_s = freeze_s;

    // FSM state, wait counter and timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_RUN;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            mem_timeout_r <= mem_timeout_nxt_s;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lu_inc_s),
        .count (lu_cnt_s)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mem_inc_s),
        .count (mem_cnt_s)
    );

    assign bus.PCWrite       = pc_write_s;
    assign bus.IFIDWrite     = ifid_write_s;
    assign bus.IDEXWrite     = idex_write_s;
    assign bus.EXMEMWrite    = exmem_write_s;
    assign bus.IDEX_bubble   = idex_bubble_s;
    assign bus.IFID_flush    = ifid_flush_s;
    assign bus.MEMWB_bubble  = memwb_bubble_s;
    assign bus.mem_timeout   = mem_timeout_r;
    assign bus.lu_stall_cnt  = lu_cnt_s;
    assign bus.mem_stall_cnt = mem_cnt_s;

endmodule
